// File: rtl/multi_voice_wavetable.sv
// Multi-voice wavetable player: double-buffered sample tables loaded from BRAM,
// voices mixed one per cycle into a saturated 16-bit output.
module multi_voice_wavetable #(
  parameter int          NUM_SAMPLES  = 256,
  parameter int          NUM_VOICES   = 4,
  parameter int          FRAC_BITS    = 8,
  parameter int          VOLUME_BITS  = 8,
  parameter int          BRAM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  localparam int         AW           = $clog2(NUM_SAMPLES),
  localparam int         PW           = AW + FRAC_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              BRAM_clk,
  output logic [31:0]                       BRAM_addr,
  output logic                              BRAM_en,
  output logic [3:0]                        BRAM_we,
  output logic [31:0]                       BRAM_din,
  output logic                              BRAM_rst,
  input  logic [31:0]                       BRAM_dout,
  input  logic                              refresh,
  input  logic                              sample_tick,
  input  logic [NUM_VOICES*PW-1:0]          phase_inc,
  input  logic [NUM_VOICES*VOLUME_BITS-1:0] volume,
  output logic                              loading,
  output logic                              loaded,
  output logic                              overrun,
  output logic                              sample_valid,
  output logic [15:0]                       mix_out
);
  localparam int WORDS = NUM_SAMPLES / 2;
  localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
  localparam int CW    = $clog2(NUM_VOICES + 1);
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_COMMIT} state_t;

  state_t                r_state;
  logic                  r_boot, r_pend, r_en, r_bram_rst, r_loading, r_loaded, r_bank;
  logic                  r_issue;
  logic [31:0]           r_addr;
  logic [AW-1:0]         r_icnt, r_wcnt;
  logic [BRAM_LATENCY:1] r_vld_pipe;
  logic [31:0]           r_mem [2][WORDS];

  logic                             r_busy, r_valid, r_overrun;
  logic [CW-1:0]                    r_vcnt;
  logic signed [ACC_W-1:0]          r_acc;
  logic [NUM_VOICES-1:0][PW-1:0]    r_phase;
  logic [15:0]                      r_mix;

  logic                             w_cap;
  logic [VW-1:0]                    w_vsel;
  logic [PW-1:0]                    w_phase, w_inc;
  logic [AW-1:0]                    w_idx;
  logic [VOLUME_BITS-1:0]           w_vol;
  logic [31:0]                      w_word;
  logic [15:0]                      w_samp, w_sat;
  logic signed [16+VOLUME_BITS:0]   w_prod;
  logic signed [ACC_W-1:0]          w_term;

  // Read data for an address issued BRAM_LATENCY cycles ago lands now.
  assign w_cap = r_vld_pipe[BRAM_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_boot     <= 1'b1;
      r_pend     <= 1'b0;
      r_en       <= 1'b0;
      r_bram_rst <= 1'b1;
      r_loading  <= 1'b0;
      r_loaded   <= 1'b0;
      r_bank     <= 1'b0;
      r_issue    <= 1'b0;
      r_addr     <= '0;
      r_icnt     <= '0;
      r_wcnt     <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_bram_rst    <= 1'b0;
      r_vld_pipe[1] <= r_issue;
      for (int i = 2; i <= BRAM_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_cap) r_wcnt <= r_wcnt + AW'(1);
      if (refresh && r_state != S_IDLE) r_pend <= 1'b1;
      case (r_state)
        S_IDLE: if (r_boot || refresh || r_pend) begin
          r_state   <= S_FILL;
          r_boot    <= 1'b0;
          r_pend    <= 1'b0;
          r_en      <= 1'b1;
          r_loading <= 1'b1;
          r_issue   <= 1'b1;
          r_addr    <= BASE_ADDR;
          r_icnt    <= AW'(1);
          r_wcnt    <= '0;
        end
        S_FILL: if (r_icnt == AW'(WORDS)) begin
          r_state <= S_DRAIN;
          r_issue <= 1'b0;
        end else begin
          r_addr <= r_addr + 32'd4;
          r_icnt <= r_icnt + AW'(1);
        end
        S_DRAIN: if (r_wcnt == AW'(WORDS)) begin
          r_state <= S_COMMIT;
          r_en    <= 1'b0;
        end
        // Swap only between mixes so one output never straddles two tables.
        S_COMMIT: if (!r_busy) begin
          r_bank    <= ~r_bank;
          r_loaded  <= 1'b1;
          r_loading <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_mem[~r_bank][r_wcnt[AW-2:0]] <= BRAM_dout;
  end

  assign w_vsel  = r_vcnt[VW-1:0];
  assign w_phase = r_phase[w_vsel];
  assign w_inc   = phase_inc[w_vsel*PW +: PW];
  assign w_vol   = volume[w_vsel*VOLUME_BITS +: VOLUME_BITS];
  assign w_idx   = w_phase[PW-1:FRAC_BITS];
  assign w_word  = r_mem[r_bank][w_idx[AW-1:1]];
  assign w_samp  = w_idx[0] ? w_word[31:16] : w_word[15:0];
  assign w_prod  = $signed({{(VOLUME_BITS+1){w_samp[15]}}, w_samp})
                 * $signed({17'd0, w_vol});
  assign w_term  = ACC_W'(w_prod >>> VOLUME_BITS);
  assign w_sat   = (r_acc > SMAX) ? 16'h7FFF :
                   (r_acc < SMIN) ? 16'h8000 : r_acc[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_vcnt    <= '0;
      r_acc     <= '0;
      r_phase   <= '0;
      r_mix     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (sample_tick && r_busy) r_overrun <= 1'b1;
      if (!r_busy) begin
        if (sample_tick) begin
          r_busy <= 1'b1;
          r_vcnt <= '0;
          r_acc  <= '0;
        end
      end else if (r_vcnt != CW'(NUM_VOICES)) begin
        r_acc            <= r_acc + w_term;
        r_phase[w_vsel]  <= w_phase + w_inc;
        r_vcnt           <= r_vcnt + CW'(1);
      end else begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
        r_mix   <= r_loaded ? w_sat : 16'h0000;
      end
    end
  end

  assign BRAM_clk     = clk;
  assign BRAM_addr    = r_addr;
  assign BRAM_en      = r_en;
  assign BRAM_we      = 4'h0;
  assign BRAM_din     = 32'h0;
  assign BRAM_rst     = r_bram_rst;
  assign loading      = r_loading;
  assign loaded       = r_loaded;
  assign overrun      = r_overrun;
  assign sample_valid = r_valid;
  assign mix_out      = r_mix;
endmodule

// File: tb/tb_multi_voice_wavetable.sv
// Scoreboard bench: stimulus pushes expected mixes computed from a plain
// arithmetic model; a negedge monitor pops and compares on every sample_valid.
module tb_multi_voice_wavetable;
  localparam int NS = 256, NV = 4, FB = 8, VB = 8, BL = 2;
  localparam int PW = 16, NW = NS / 2;
  localparam logic [31:0] BASE = 32'h0;

  logic clk, rst_n, refresh, sample_tick;
  logic BRAM_clk, BRAM_en, BRAM_rst, loading, loaded, overrun, sample_valid;
  logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
  logic [3:0]  BRAM_we;
  logic [NV*PW-1:0] phase_inc;
  logic [NV*VB-1:0] volume;
  logic [15:0] mix_out;

  multi_voice_wavetable #(.NUM_SAMPLES(NS), .NUM_VOICES(NV), .FRAC_BITS(FB),
    .VOLUME_BITS(VB), .BRAM_LATENCY(BL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .BRAM_clk(BRAM_clk), .BRAM_addr(BRAM_addr),
    .BRAM_en(BRAM_en), .BRAM_we(BRAM_we), .BRAM_din(BRAM_din), .BRAM_rst(BRAM_rst),
    .BRAM_dout(BRAM_dout), .refresh(refresh), .sample_tick(sample_tick),
    .phase_inc(phase_inc), .volume(volume), .loading(loading), .loaded(loaded),
    .overrun(overrun), .sample_valid(sample_valid), .mix_out(mix_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] bram_tab [NS];
  logic [15:0] act_tab  [NS];
  int  mphase [NV];
  bit  mloaded, moverrun, amb, seen_new, we_bad;
  int  next_ok, en_rises;

  typedef struct { int a; int b; int cyc; } exp_t;
  exp_t q[$];

  // BRAM: registered read, BL cycles from address to data
  logic [31:0] rd_pipe [BL];
  function automatic logic [31:0] word_at(input logic [31:0] a);
    int k = int'((a - BASE) >> 2) % NW;
    return {bram_tab[2*k+1], bram_tab[2*k]};
  endfunction
  always @(posedge clk) begin
    rd_pipe[0] <= word_at(BRAM_addr);
    for (int i = 1; i < BL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign BRAM_dout = rd_pipe[BL-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Mix value from the spec's rules: truncated index, (s*vol)>>>VB, saturate.
  function automatic int mix_calc(input bit use_new);
    int sum, idx, s, vol;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      idx = (mphase[v] >> FB) % NS;
      s   = use_new ? int'($signed(bram_tab[idx])) : int'($signed(act_tab[idx]));
      vol = int'(volume[v*VB +: VB]);
      sum += (s * vol) >>> VB;
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return mloaded ? sum : 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_tick(input bit refr = 1'b0);
    exp_t e;
    int edge_n = cyc + 1;
    if (edge_n >= next_ok) begin
      e.a = mix_calc(1'b0);
      e.b = amb ? mix_calc(1'b1) : e.a;
      e.cyc = cyc + NV + 2;
      q.push_back(e);
      for (int v = 0; v < NV; v++)
        mphase[v] = (mphase[v] + int'(phase_inc[v*PW +: PW])) % 65536;
      next_ok = edge_n + NV + 2;
    end else moverrun = 1'b1;
    sample_tick = 1'b1; refresh = refr;
    @(posedge clk); #1;
    sample_tick = 1'b0; refresh = 1'b0;
  endtask

  task automatic mreset();
    for (int v = 0; v < NV; v++) mphase[v] = 0;
    mloaded = 0; moverrun = 0; next_ok = 0; q.delete();
  endtask

  task automatic wait_loading(input logic val, input int lim, input string nm);
    int n = 0;
    while (loading !== val && n < lim) begin idle(1); n++; end
    chk(nm, longint'(loading), longint'(val));
  endtask

  task automatic load_done();
    wait_loading(1'b1, 20, "load_start");
    wait_loading(1'b0, 2000, "load_end");
    for (int i = 0; i < NS; i++) act_tab[i] = bram_tab[i];
    mloaded = 1;
    chk("loaded", longint'(loaded), 1);
  endtask

  task automatic do_refresh();
    refresh = 1'b1; idle(1); refresh = 1'b0;
    load_done();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_addr"}, longint'(BRAM_addr), 0);
    chk({tag, "_en"}, longint'(BRAM_en), 0);
    chk({tag, "_bram_rst"}, longint'(BRAM_rst), 1);
    chk({tag, "_we"}, longint'(BRAM_we), 0);
    chk({tag, "_din"}, longint'(BRAM_din), 0);
    chk({tag, "_loading"}, longint'(loading), 0);
    chk({tag, "_loaded"}, longint'(loaded), 0);
    chk({tag, "_overrun"}, longint'(overrun), 0);
    chk({tag, "_valid"}, longint'(sample_valid), 0);
    chk({tag, "_mix"}, longint'(mix_out), 0);
  endtask

  task automatic set_voice(input int v, input int inc, input int vol);
    phase_inc[v*PW +: PW] = PW'(inc);
    volume[v*VB +: VB]    = VB'(vol);
  endtask

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    int m;
    if (rst_n && sample_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_valid got mix %0d expected no output", $signed(mix_out));
      end else begin
        e = q.pop_front();
        m = int'($signed(mix_out));
        chk("valid_latency_cycle", cyc, e.cyc);
        checks++;
        if (m == e.a && (e.a == e.b || !seen_new)) ;
        else if (m == e.b) seen_new = seen_new | (e.a != e.b);
        else begin
          errors++;
          $display("FAIL mix got %0d expected %0d (alt %0d)", m, e.a, e.b);
        end
      end
    end
  end

  // BRAM read-address monitor: ascending word addresses, NW per load
  bit prev_en; int ak; logic [31:0] aprev;
  always @(negedge clk) begin
    if (BRAM_we !== 4'h0 || BRAM_din !== 32'h0) we_bad = 1'b1;
    if (!rst_n) prev_en = 1'b0;
    else begin
      if (BRAM_en && !prev_en) begin en_rises++; ak = 0; aprev = 32'hFFFF_FFFF; end
      if (BRAM_en && BRAM_addr != aprev) begin
        chk("bram_addr", longint'(BRAM_addr), longint'(BASE + 32'(4 * ak)));
        ak++; aprev = BRAM_addr;
      end
      if (!BRAM_en && prev_en) chk("reads_per_load", ak, NW);
      prev_en = BRAM_en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, g;
    rst_n = 1'b0; refresh = 1'b0; sample_tick = 1'b0;
    phase_inc = '0; volume = '0; amb = 0; seen_new = 0; we_bad = 0; en_rises = 0;
    for (int i = 0; i < NS; i++) begin bram_tab[i] = 16'(i); act_tab[i] = '0; end
    mreset();
    @(posedge clk); #1;
    idle(2);
    check_reset_outs("por");

    rst_n = 1'b1;
    idle(1);
    chk("bram_rst_release", longint'(BRAM_rst), 0);
    chk("fill_after_release", longint'(loading), 1);
    chk("en_after_release", longint'(BRAM_en), 1);

    // Ticks before the first commit must produce zero
    set_voice(1, 5 << FB, 255);
    pulse_tick(); idle(NV + 3);
    pulse_tick(); idle(NV + 3);
    load_done();
    chk("overrun_clear", longint'(overrun), longint'(moverrun));

    // Single voice ramp: 0,0,1,2
    set_voice(1, 0, 0);
    set_voice(0, 1 << FB, 255);
    repeat (4) begin pulse_tick(); idle(NV + 3); end

    // Back-to-back tick: second dropped
    pulse_tick(); pulse_tick(); idle(NV + 3);
    chk("overrun_set", longint'(overrun), longint'(moverrun));

    // Phase wrap 0xFFFF + 0x0101 -> 0x0100
    set_voice(0, 16'hFFFF - mphase[0], 255);
    pulse_tick(); idle(NV + 3);
    set_voice(0, 16'h0101, 255);
    pulse_tick(); idle(NV + 3);
    pulse_tick(); idle(NV + 3);
    pulse_tick(); idle(NV + 3);

    // Saturation both ways
    for (int v = 0; v < NV; v++) set_voice(v, int'($urandom_range(0, 65535)), 255);
    for (int i = 0; i < NS; i++) bram_tab[i] = 16'h7FFF;
    do_refresh();
    repeat (2) begin pulse_tick(); idle(NV + 3); end
    for (int i = 0; i < NS; i++) bram_tab[i] = 16'h8000;
    do_refresh();
    repeat (2) begin pulse_tick(); idle(NV + 3); end

    // Random table, random increments/volumes, occasional dropped ticks
    for (int i = 0; i < NS; i++) bram_tab[i] = 16'($urandom);
    do_refresh();
    for (int it = 0; it < 30; it++) begin
      for (int v = 0; v < NV; v++)
        set_voice(v, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
      pulse_tick();
      g = int'($urandom_range(0, NV + 3));
      idle(g);
      if ($urandom_range(0, 1) == 1) pulse_tick();
      idle(NV + 3);
    end
    chk("overrun_random", longint'(overrun), longint'(moverrun));

    // Refresh during FILL plus a second refresh: two loads, ticks throughout
    for (int i = 0; i < NS; i++) bram_tab[i] = 16'($urandom);
    for (int v = 0; v < NV; v++) set_voice(v, int'($urandom_range(256, 65535)), 255);
    amb = 1; seen_new = 0; e0 = en_rises;
    for (int it = 0; it < 70; it++) begin
      pulse_tick(it == 0 || it == 3);
      idle(int'($urandom_range(NV + 1, NV + 4)));
    end
    idle(NV + 3);
    amb = 0;
    wait_loading(1'b0, 2000, "b2b_done");
    chk("b2b_load_count", en_rises - e0, 2);
    chk("b2b_new_table_seen", longint'(seen_new), 1);
    for (int i = 0; i < NS; i++) act_tab[i] = bram_tab[i];

    // Reset in the middle of FILL
    refresh = 1'b1; idle(1); refresh = 1'b0;
    idle(20);
    rst_n = 1'b0; #1;
    check_reset_outs("midfill");
    mreset();
    idle(3);
    rst_n = 1'b1;
    load_done();
    for (int v = 0; v < NV; v++) set_voice(v, int'($urandom_range(0, 65535)), 255);
    repeat (3) begin pulse_tick(); idle(NV + 3); end

    idle(NV + 5);
    chk("scoreboard_empty", q.size(), 0);
    chk("we_din_zero", longint'(we_bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
